// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button conditioner.
//   state_e            : 3-bit FSM state codes (INI..WR); code 3'd7 is unused
//   DEF_*_BITS         : default timing exponents, shared by the board top and the bench
//   max3()             : width helper for the shared counter
package button_debouncer_pkg;

  typedef enum logic [2:0] {
    ST_INI    = 3'd0,
    ST_WQ     = 3'd1,
    ST_SCEN   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_MCEN   = 3'd4,
    ST_REPEAT = 3'd5,
    ST_WR     = 3'd6
  } state_e;

  localparam int unsigned DEF_DEBOUNCE_BITS = 20;
  localparam int unsigned DEF_HOLD_BITS     = 26;
  localparam int unsigned DEF_REPEAT_BITS   = 23;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button signal bundle.
//   PB   : raw asynchronous button level (from the pad)
//   DPB  : debounced level
//   SCEN : one-clock pulse per debounced press
//   MCEN : pulse on press, then auto-repeat pulses while held
// slave  : the debouncer side (consumes PB, produces DPB/SCEN/MCEN)
// master : the user side (drives PB, consumes DPB/SCEN/MCEN)
interface button_debouncer_if;
  logic PB;
  logic DPB;
  logic SCEN;
  logic MCEN;

  modport slave  (input  PB, output DPB, output SCEN, output MCEN);
  modport master (output PB, input  DPB, input  SCEN, input  MCEN);
endinterface

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk : destination clock
//   rst : synchronous, active-high reset (clears both flops)
//   d   : asynchronous input
//   q   : synchronised output, two clocks behind d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronise, debounce, and generate press / auto-repeat enables.
//   Clk   : system clock
//   Reset : synchronous, active-high reset
//   bif   : slave side of button_debouncer_if (PB in; DPB, SCEN, MCEN out)
// One shared counter times every state; it clears on any state change, so each
// state measures from its own entry. Outputs are a pure decode of the state.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_BITS = DEF_DEBOUNCE_BITS,
  parameter int unsigned HOLD_BITS     = DEF_HOLD_BITS,
  parameter int unsigned REPEAT_BITS   = DEF_REPEAT_BITS
) (
  input logic           Clk,
  input logic           Reset,
  button_debouncer_if.slave bif
);

  localparam int unsigned CNT_W = max3(DEBOUNCE_BITS, HOLD_BITS, REPEAT_BITS);

  // Terminal masks: all-ones in the low N bits of the shared counter.
  localparam logic [CNT_W-1:0] DB_TERM   = CNT_W'((64'd1 << DEBOUNCE_BITS) - 64'd1);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'((64'd1 << HOLD_BITS) - 64'd1);
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'((64'd1 << REPEAT_BITS) - 64'd1);

  function automatic logic at_term(input logic [CNT_W-1:0] cnt,
                                   input logic [CNT_W-1:0] term);
    return (cnt & term) == term;
  endfunction

  logic             pb_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sync_2ff u_sync (
    .clk (Clk),
    .rst (Reset),
    .d   (bif.PB),
    .q   (pb_s)
  );

  // Next state. A level change on pb_s is tested before the counter terminal,
  // so a bounce coinciding with the terminal restarts the wait instead of committing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INI:    if (pb_s) state_d = ST_WQ;
      ST_WQ:     if (!pb_s) state_d = ST_INI;
                 else if (at_term(cnt_q, DB_TERM)) state_d = ST_SCEN;
      ST_SCEN:   state_d = ST_HOLD;
      ST_HOLD:   if (!pb_s) state_d = ST_WR;
                 else if (at_term(cnt_q, HOLD_TERM)) state_d = ST_MCEN;
      ST_MCEN:   state_d = ST_REPEAT;
      ST_REPEAT: if (!pb_s) state_d = ST_WR;
                 else if (at_term(cnt_q, REP_TERM)) state_d = ST_MCEN;
      // A bounce back high while waiting out a release resumes holding without a new press.
      ST_WR:     if (pb_s) state_d = ST_HOLD;
                 else if (at_term(cnt_q, DB_TERM)) state_d = ST_INI;
      default:   state_d = ST_INI;
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_INI;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode.
  always_comb begin
    bif.DPB  = 1'b0;
    bif.SCEN = 1'b0;
    bif.MCEN = 1'b0;
    case (state_q)
      ST_SCEN: begin
        bif.DPB  = 1'b1;
        bif.SCEN = 1'b1;
        bif.MCEN = 1'b1;
      end
      ST_MCEN: begin
        bif.DPB  = 1'b1;
        bif.MCEN = 1'b1;
      end
      ST_HOLD, ST_REPEAT, ST_WR: bif.DPB = 1'b1;
      default: ;
    endcase
  end

endmodule
